// File: rtl/rob_checkpoint_ctrl_pkg.sv
// Shared constants and the recovery FSM state type for the ROB branch-checkpoint controller.
package rob_checkpoint_ctrl_pkg;

    localparam int ROB_LENGTH = 32;
    localparam int NUM_CKPT   = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RESTORE,
        ST_DRAIN
    } ckpt_state_e;

endpackage

// File: rtl/rob_checkpoint_ctrl.sv
// Branch checkpoint queue: allocates a slot per dispatched branch, frees slots in program
// order as branches resolve, and sequences a two-cycle ROB tail restore on a mispredict.
module rob_checkpoint_ctrl #(
    parameter int NUM_CKPT   = rob_checkpoint_ctrl_pkg::NUM_CKPT,
    parameter int ROB_LENGTH = rob_checkpoint_ctrl_pkg::ROB_LENGTH
) (
    input  logic                          clk,
    input  logic                          n_rst,
    input  logic                          br_dispatch,
    input  logic [$clog2(ROB_LENGTH)-1:0] dispatch_tail,
    output logic                          ckpt_accept,
    output logic [$clog2(NUM_CKPT)-1:0]   ckpt_id,
    output logic                          ckpt_full,
    input  logic                          br_resolve,
    input  logic [$clog2(NUM_CKPT)-1:0]   br_resolve_id,
    input  logic                          br_mispredict,
    output logic                          restore,
    output logic [$clog2(ROB_LENGTH)-1:0] restore_tail,
    output logic                          flush_stall
);
    import rob_checkpoint_ctrl_pkg::*;

    localparam int IDW = $clog2(NUM_CKPT);
    localparam int TW  = $clog2(ROB_LENGTH);
    localparam int CW  = IDW + 1;

    logic [NUM_CKPT-1:0] live_q, live_d;
    logic [NUM_CKPT-1:0] res_q, res_d;
    logic [TW-1:0]       tail_q [NUM_CKPT];
    logic [IDW-1:0]      head_q, head_d;
    logic [IDW-1:0]      alloc_q, alloc_d;
    logic [CW-1:0]       count_q, count_d;
    ckpt_state_e         state_q, state_d;
    logic                restore_q, restore_d;
    logic                flush_q, flush_d;
    logic [TW-1:0]       rtail_q, rtail_d;

    logic misp_req, misp_live, good_res, free;

    // Distance of a slot from the queue head, i.e. its age rank in program order.
    function automatic logic [IDW-1:0] age(input logic [IDW-1:0] slot, input logic [IDW-1:0] base);
        return slot - base;
    endfunction

    assign misp_req  = br_resolve & br_mispredict;
    assign misp_live = misp_req & live_q[br_resolve_id] & (state_q == ST_IDLE);
    assign good_res  = br_resolve & ~br_mispredict & live_q[br_resolve_id];
    // A head slot being squashed by its own mispredict is not also freed.
    assign free      = live_q[head_q] & res_q[head_q] & ~(misp_live & (br_resolve_id == head_q));

    assign ckpt_full   = (count_q == CW'(NUM_CKPT)) & ~free;
    assign ckpt_accept = br_dispatch & ~ckpt_full & (state_q == ST_IDLE) & ~misp_req;
    assign ckpt_id     = alloc_q;

    assign restore      = restore_q;
    assign restore_tail = rtail_q;
    assign flush_stall  = flush_q;

    always_comb begin
        live_d  = live_q;
        res_d   = res_q;
        head_d  = head_q;
        alloc_d = alloc_q;
        count_d = count_q;
        state_d = state_q;
        rtail_d = rtail_q;

        if (good_res) begin
            res_d[br_resolve_id] = 1'b1;
        end
        if (free) begin
            live_d[head_q] = 1'b0;
            res_d[head_q]  = 1'b0;
            head_d         = head_q + 1'b1;
        end

        if (misp_live) begin
            for (int i = 0; i < NUM_CKPT; i++) begin
                if (age(IDW'(i), head_q) >= age(br_resolve_id, head_q)) begin
                    live_d[i] = 1'b0;
                    res_d[i]  = 1'b0;
                end
            end
            alloc_d = br_resolve_id;
            count_d = {1'b0, age(br_resolve_id, head_d)};
        end else begin
            // Allocation is applied after the free so a reused head slot ends up live.
            if (ckpt_accept) begin
                live_d[alloc_q] = 1'b1;
                res_d[alloc_q]  = 1'b0;
                alloc_d         = alloc_q + 1'b1;
            end
            count_d = count_q + CW'(ckpt_accept) - CW'(free);
        end

        case (state_q)
            ST_IDLE: begin
                if (misp_live) begin
                    state_d = ST_RESTORE;
                    rtail_d = tail_q[br_resolve_id];
                end
            end
            ST_RESTORE: state_d = ST_DRAIN;
            ST_DRAIN:   state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase

        restore_d = (state_d == ST_RESTORE);
        flush_d   = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            live_q    <= '0;
            res_q     <= '0;
            head_q    <= '0;
            alloc_q   <= '0;
            count_q   <= '0;
            state_q   <= ST_IDLE;
            restore_q <= 1'b0;
            flush_q   <= 1'b0;
            rtail_q   <= '0;
        end else begin
            live_q    <= live_d;
            res_q     <= res_d;
            head_q    <= head_d;
            alloc_q   <= alloc_d;
            count_q   <= count_d;
            state_q   <= state_d;
            restore_q <= restore_d;
            flush_q   <= flush_d;
            rtail_q   <= rtail_d;
        end
    end

    // Tail payload is only meaningful while its live bit is set, so it needs no reset.
    always_ff @(posedge clk) begin
        if (ckpt_accept) begin
            tail_q[alloc_q] <= dispatch_tail;
        end
    end

endmodule
